// File: rtl/pipeline_acc.sv
// Frame accumulator: sums 2^LOG2_N accepted samples, then holds the sum and its average
// until the downstream handshake.
module pipeline_acc #(
    parameter int unsigned LOG2_N = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                clr,
    output logic [12+LOG2_N-1:0] out_sum,
    output logic [11:0]         out_avg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          frame_cnt
);

    localparam int unsigned SW = 12 + LOG2_N;

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [SW-1:0]   acc_next;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            accept;
    logic            last;

    assign in_ready = (state_q == StAccum) && !clr;
    assign accept   = in_valid && in_ready;
    assign acc_next = acc_q + SW'(in_data);
    // cnt counts 0..N-1, so all-ones marks the final sample of the frame
    assign last     = &cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            StAccum: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    if (last) begin
                        sum_d   = acc_next;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    fcnt_d  = fcnt_q + 8'd1;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_avg   = sum_q[SW-1:LOG2_N];
    assign out_valid = valid_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_pipeline_acc.sv
// Bench for pipeline_acc: vector table, directed corner sequences and a randomized run
// against a queue-based frame model.
module tb_pipeline_acc;

    localparam int unsigned L = 2;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid, clr, out_ready;
    logic        in_ready, out_valid;
    logic [13:0] out_sum;
    logic [11:0] out_avg;
    logic [7:0]  frame_cnt;

    logic [11:0] d1;
    logic        v1, clr1, r1, rdy1, ov1;
    logic [12:0] sum1;
    logic [11:0] avg1;
    logic [7:0]  fc1;

    pipeline_acc #(.LOG2_N(L)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .clr(clr), .out_sum(out_sum), .out_avg(out_avg), .out_valid(out_valid),
        .out_ready(out_ready), .frame_cnt(frame_cnt)
    );

    pipeline_acc #(.LOG2_N(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
        .clr(clr1), .out_sum(sum1), .out_avg(avg1), .out_valid(ov1),
        .out_ready(r1), .frame_cnt(fc1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int d; bit v; bit c; bit r;
        bit rdy; bit ov; int sum; int avg; int fc;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int d, input bit v, input bit c, input bit r, input bit rdy,
                       input bit ov, input int sum, input int avg, input int fc);
        vec_t e;
        e.d = d; e.v = v; e.c = c; e.r = r;
        e.rdy = rdy; e.ov = ov; e.sum = sum; e.avg = avg; e.fc = fc;
        tbl.push_back(e);
    endtask

    // Frame-level reference: pending samples of the open frame and at most one held result
    int part[$];
    bit m_hold;
    int m_sum;
    int m_frames;

    task automatic model_reset();
        part.delete();
        m_hold = 0;
        m_sum = 0;
        m_frames = 0;
    endtask

    task automatic mcycle(input int d, input bit v, input bit c, input bit r);
        in_data = d[11:0]; in_valid = v; clr = c; out_ready = r;
        #1;
        check("in_ready", int'(in_ready), int'(!m_hold && !c));
        @(posedge clk);
        if (m_hold) begin
            if (r) begin
                m_hold = 0;
                m_frames = (m_frames + 1) % 256;
            end
        end else if (c) begin
            part.delete();
        end else if (v) begin
            part.push_back(d);
            if (part.size() == N) begin
                m_sum = 0;
                foreach (part[i]) m_sum += part[i];
                m_hold = 1;
                part.delete();
            end
        end
        #1;
        check("out_valid", int'(out_valid), int'(m_hold));
        if (m_hold) begin
            check("out_sum", int'(out_sum), m_sum);
            check("out_avg", int'(out_avg), m_sum / N);
        end
        check("frame_cnt", int'(frame_cnt), m_frames);
    endtask

    // Called just after a rising edge; pulses rst between edges and checks the async clear
    task automatic do_rst();
        in_valid = 0; clr = 0; out_ready = 0;
        #1 rst = 1;
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_sum", int'(out_sum), 0);
        check("rst out_avg", int'(out_avg), 0);
        check("rst frame_cnt", int'(frame_cnt), 0);
        check("rst in_ready", int'(in_ready), 1);
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_data = 0; in_valid = 0; clr = 0; out_ready = 0;
        d1 = 0; v1 = 0; clr1 = 0; r1 = 1;
        #3;
        check("init out_valid", int'(out_valid), 0);
        check("init out_sum", int'(out_sum), 0);
        check("init out_avg", int'(out_avg), 0);
        check("init frame_cnt", int'(frame_cnt), 0);
        check("init in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        model_reset();

        // LOG2_N=1 instance: two samples per frame
        d1 = 12'd7; v1 = 1;
        @(posedge clk); #1;
        d1 = 12'd8;
        @(posedge clk); #1;
        v1 = 0;
        check("n2 out_valid", int'(ov1), 1);
        check("n2 out_sum", int'(sum1), 15);
        check("n2 out_avg", int'(avg1), 7);
        @(posedge clk); #1;
        check("n2 frame_cnt", int'(fc1), 1);

        // Basic frame, then clr overriding in_valid mid-frame
        add(100, 1, 0, 1, 1, 0, 0, 0, 0);
        add(200, 1, 0, 1, 1, 0, 0, 0, 0);
        add(300, 1, 0, 1, 1, 0, 0, 0, 0);
        add(400, 1, 0, 1, 1, 1, 1000, 250, 0);
        add(0,   0, 0, 1, 0, 0, 0, 0, 1);
        add(10,  1, 0, 1, 1, 0, 0, 0, 1);
        add(20,  1, 0, 1, 1, 0, 0, 0, 1);
        add(30,  1, 1, 1, 0, 0, 0, 0, 1);
        add(1,   1, 0, 1, 1, 0, 0, 0, 1);
        add(2,   1, 0, 1, 1, 0, 0, 0, 1);
        add(3,   1, 0, 1, 1, 0, 0, 0, 1);
        add(4,   1, 0, 1, 1, 1, 10, 2, 1);
        add(0,   0, 0, 1, 0, 0, 0, 0, 2);
        foreach (tbl[i]) begin
            in_data = tbl[i].d[11:0]; in_valid = tbl[i].v; clr = tbl[i].c;
            out_ready = tbl[i].r;
            #1;
            check($sformatf("tbl%0d in_ready", i), int'(in_ready), int'(tbl[i].rdy));
            @(posedge clk); #1;
            check($sformatf("tbl%0d out_valid", i), int'(out_valid), int'(tbl[i].ov));
            check($sformatf("tbl%0d frame_cnt", i), int'(frame_cnt), tbl[i].fc);
            if (tbl[i].ov) begin
                check($sformatf("tbl%0d out_sum", i), int'(out_sum), tbl[i].sum);
                check($sformatf("tbl%0d out_avg", i), int'(out_avg), tbl[i].avg);
            end
        end

        // Full-scale frame with a 5-cycle downstream stall
        do_rst();
        repeat (4) mcycle(4095, 1, 0, 0);
        check("stall sum", int'(out_sum), 16380);
        check("stall avg", int'(out_avg), 4095);
        repeat (5) begin
            mcycle(4095, 1, 0, 0);
            check("stall in_ready", int'(in_ready), 0);
            check("stall hold sum", int'(out_sum), 16380);
        end
        mcycle(4095, 1, 0, 1);
        check("stall release fc", int'(frame_cnt), 1);
        mcycle(7, 1, 0, 1);
        repeat (3) mcycle(1, 1, 0, 1);
        check("post stall sum", int'(out_sum), 10);
        mcycle(0, 0, 0, 1);

        // Gapped partial frame discarded by an async reset pulse
        mcycle(5, 1, 0, 1);
        mcycle(0, 0, 0, 1);
        mcycle(6, 1, 0, 1);
        mcycle(0, 0, 0, 1);
        mcycle(7, 1, 0, 1);
        do_rst();
        repeat (4) mcycle(1, 1, 0, 1);
        check("after rst sum", int'(out_sum), 4);
        mcycle(0, 0, 0, 1);

        // 256 back-to-back frames: frame_cnt wraps to 0
        do_rst();
        for (int f = 0; f < 256; f++) begin
            repeat (4) mcycle(int'($urandom_range(0, 4095)), 1, 0, 1);
            mcycle(int'($urandom_range(0, 4095)), 1, 0, 1);
            if (f == 254) check("fc 255", int'(frame_cnt), 255);
        end
        check("fc wrap", int'(frame_cnt), 0);

        // Randomized traffic against the frame model
        for (int k = 0; k < 3000; k++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? 4095 : int'($urandom_range(0, 4095));
            mcycle(d, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 9) < 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_acc.md
PIPELINE_ACC -- requirements
Module: pipeline_acc

Interface
REQ-001 Parameter LOG2_N, default 2: the block accumulates N = 2^LOG2_N samples per frame; legal range is 1..4.
REQ-002 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1: asynchronous, active-high reset; it SHALL take effect immediately on assertion without waiting for clk.
REQ-004 in_data  input  12: unsigned sample from the upstream three-operand adder stage.
REQ-005 in_valid  input  1: in_data is valid this cycle.
REQ-006 in_ready  output  1: the block accepts in_data this cycle.
REQ-007 clr  input  1: synchronous frame abort.
REQ-008 out_sum  output  12+LOG2_N: unsigned sum of the N samples in the frame.
REQ-009 out_avg  output  12: out_sum shifted right by LOG2_N (truncated).
REQ-010 out_valid  output  1: out_sum/out_avg hold a completed frame.
REQ-011 out_ready  input  1: downstream accepts the result this cycle.
REQ-012 frame_cnt  output  8: count of completed frames handed off downstream.

Function
REQ-013 States SHALL be ACCUM and HOLD; in_ready SHALL be 1 exactly when state is ACCUM and clr is 0 (combinational).
REQ-014 Accept SHALL occur only when in_valid and in_ready are both 1; on accept, acc <= acc + in_data and cnt <= cnt + 1.
REQ-015 acc SHALL be 12+LOG2_N bits wide; no overflow is possible, and no saturation SHALL be applied.
REQ-016 On the accept that makes cnt reach N: out_sum <= acc + in_data, out_valid <= 1, acc <= 0, cnt <= 0, state <= HOLD; the result SHALL appear on the next clock edge (latency of 1 clock from the last sample).
REQ-017 In HOLD, out_sum, out_avg and out_valid SHALL stay stable until out_valid and out_ready are both 1; on that cycle out_valid <= 0, frame_cnt <= frame_cnt + 1, and state <= ACCUM.
REQ-018 frame_cnt SHALL wrap from 255 to 0 with no flag.
REQ-019 Cycles with in_valid at 0 in ACCUM SHALL leave acc and cnt unchanged, i.e. gaps are allowed mid-frame.
REQ-020 out_avg SHALL be derived combinationally from the registered out_sum.
REQ-021 clr in ACCUM SHALL set acc <= 0 and cnt <= 0; no sample is accepted that cycle; clr overrides a simultaneous in_valid.
REQ-022 clr in HOLD SHALL have no effect; the pending result stays valid until handshaken.
REQ-023 out_ready while out_valid is 0 SHALL be ignored.
REQ-024 The block SHALL never drop or duplicate a sample or a result.

Reset
REQ-025 While rst is 1: state = ACCUM, acc = 0, cnt = 0, out_sum = 0, out_valid = 0, frame_cnt = 0; consequently in_ready = 1 once clr is 0 and out_avg = 0.
REQ-026 rst asserted mid-frame or during HOLD SHALL discard the partial frame and the pending result; the first accepted sample after release SHALL start a new frame.

Verification
REQ-027 LOG2_N=2; samples 100, 200, 300, 400 on consecutive cycles, out_ready=1 -> out_valid high 1 clock after the 400 is accepted, out_sum=1000, out_avg=250; frame_cnt becomes 1 on the following edge.
REQ-028 Four samples of 4095, out_ready held 0 for 5 cycles -> out_sum=16380, out_avg=4095, stable while stalled, in_ready=0 throughout the stall; a 5th in_valid is not accepted until after the handshake.
REQ-029 Samples 10, 20, then clr together with in_valid carrying 30, then 1, 2, 3, 4 -> out_sum=10, out_avg=2; the 30 is not accepted.
REQ-030 Samples 5, 6, 7 with idle gaps between them, then rst pulsed for 1 ns between edges -> all outputs at 0 immediately; next frame 1, 1, 1, 1 -> out_sum=4.
REQ-031 256 back-to-back frames handshaken -> frame_cnt reads 0 after the 256th frame, with no glitch on out_valid.
REQ-032 LOG2_N=1; samples 7 and 8 -> out_sum=15 (13 bits), out_avg=7.
